// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: round-robin two-port front end that sequences the serial Booth core's start/data protocol
module booth_mul_arbiter #(
  parameter int WIDTH   = 8,
  parameter int M_HOLD  = 3,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b0,
  input  logic [WIDTH-1:0]   b1,
  output logic               ack0,
  output logic               ack1,
  output logic [2*WIDTH-1:0] result,
  output logic               result_valid,
  output logic               result_id,
  output logic               result_err,
  output logic               busy,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_data,
  input  logic               mul_done,
  input  logic [2*WIDTH-1:0] mul_product
);
  localparam int CW = $clog2(TIMEOUT + M_HOLD) + 1;
  typedef enum logic [2:0] {IDLE, LOAD_M, LOAD_Q, RESP, GAP} state_t;
  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   b_q;
  logic               id_q;
  logic               last_q;
  logic               gnt1;
  logic               idle;
  logic [2*WIDTH-1:0] result_q;
  logic               valid_q;
  logic               rid_q;
  logic               err_q;
  logic               busy_q;
  logic               start_q;
  logic [WIDTH-1:0]   data_q;
  // on a tie requester 1 wins only if 0 was served last
  assign gnt1 = req1 & (~req0 | ~last_q);
  assign idle = rst_n & (state_q == IDLE);
  assign ack1 = idle & gnt1;
  assign ack0 = idle & req0 & ~gnt1;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign result_id    = rid_q;
  assign result_err   = err_q;
  assign busy         = busy_q;
  assign mul_start    = start_q;
  assign mul_data     = data_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      b_q      <= '0;
      id_q     <= 1'b0;
      last_q   <= 1'b1;
      result_q <= '0;
      valid_q  <= 1'b0;
      rid_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (ack0 | ack1) begin
          b_q     <= gnt1 ? b1 : b0;
          id_q    <= gnt1;
          cnt_q   <= '0;
          start_q <= 1'b1;
          data_q  <= gnt1 ? a1 : a0;
          busy_q  <= 1'b1;
          state_q <= LOAD_M;
        end
        LOAD_M: if (cnt_q == CW'(M_HOLD - 1)) begin
          cnt_q   <= '0;
          data_q  <= b_q;
          state_q <= LOAD_Q;
        end else cnt_q <= cnt_q + CW'(1);
        // done takes priority over a coincident timeout
        LOAD_Q: if (mul_done || cnt_q == CW'(TIMEOUT - 1)) begin
          start_q  <= 1'b0;
          data_q   <= '0;
          result_q <= mul_done ? mul_product : '0;
          err_q    <= ~mul_done;
          rid_q    <= id_q;
          valid_q  <= 1'b1;
          state_q  <= RESP;
        end else cnt_q <= cnt_q + CW'(1);
        RESP: begin
          valid_q <= 1'b0;
          last_q  <= id_q;
          state_q <= GAP;
        end
        GAP: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_mul_arbiter.sv
// tb_booth_mul_arbiter: directed bench with a transaction-level model and a behavioural Booth core stub
module tb_booth_mul_arbiter;
  localparam int M_HOLD = 3, TIMEOUT = 64, LAT = 2;
  logic clk, rst_n, req0, req1, ack0, ack1, result_valid, result_id, result_err, busy, mul_start, mul_done;
  logic [7:0] a0, a1, b0, b1, mul_data;
  logic [15:0] result, mul_product;
  int tests = 0, fails = 0, mode = 0, cyc = 0, scnt = 0;
  booth_mul_arbiter #(.WIDTH(8), .M_HOLD(M_HOLD), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .ack0(ack0), .ack1(ack1), .result(result), .result_valid(result_valid), .result_id(result_id),
    .result_err(result_err), .busy(busy), .mul_start(mul_start), .mul_data(mul_data),
    .mul_done(mul_done), .mul_product(mul_product));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // core stub: multiplicand is the first start cycle's data, multiplier the latest; mode 1 never finishes, mode 2 also raises a stale done while loading the multiplicand
  logic signed [7:0] ma_s = '0, mq_s = '0;
  always @(posedge clk) begin
    if (mul_start) begin
      scnt <= scnt + 1;
      if (scnt == 0) ma_s <= mul_data;
      mq_s <= mul_data;
    end else scnt <= 0;
  end
  assign mul_product = 16'(ma_s) * 16'(mq_s);
  assign mul_done = (mode != 1 && mul_start && scnt == M_HOLD + LAT) || (mode == 2 && mul_start && scnt < M_HOLD);
  // transaction model: one outstanding op, expected waveform derived from cycles since grant
  logic [7:0] ma_m, mb_m;
  logic [15:0] r_m;
  logic id_m, err_m, act_m = 1'b0, last_m = 1'b1, pend_m = 1'b1, any_m, eid_m;
  int g_m, lat_m, k;
  always @(negedge clk) begin
    cyc++;
    if (pend_m) begin
      act_m = 1'b0;
      last_m = 1'b1;
    end
    if (act_m && cyc - g_m == lat_m + 2) begin
      last_m = id_m;
      act_m = 1'b0;
    end
    if (!act_m) begin
      any_m = rst_n && (req0 || req1);
      eid_m = (req0 && req1) ? !last_m : req1;
      chk("ack0", 32'(ack0), 32'(any_m && !eid_m));
      chk("ack1", 32'(ack1), 32'(any_m && eid_m));
      chk("idle_busy", 32'(busy), 0);
      chk("idle_start", 32'(mul_start), 0);
      chk("idle_data", 32'(mul_data), 0);
      chk("idle_valid", 32'(result_valid), 0);
      if (any_m) begin
        act_m = 1'b1;
        g_m = cyc;
        id_m = eid_m;
        ma_m = eid_m ? a1 : a0;
        mb_m = eid_m ? b1 : b0;
        err_m = (mode == 1);
        lat_m = err_m ? M_HOLD + 1 + TIMEOUT : M_HOLD + LAT + 2;
        r_m = err_m ? 16'h0 : 16'(signed'(ma_m)) * 16'(signed'(mb_m));
      end
    end else begin
      k = cyc - g_m;
      chk("busy_ack0", 32'(ack0), 0);
      chk("busy_ack1", 32'(ack1), 0);
      chk("busy", 32'(busy), 1);
      chk("valid", 32'(result_valid), 32'(k == lat_m));
      chk("start", 32'(mul_start), 32'(k < lat_m));
      chk("data", 32'(mul_data), 32'(k <= M_HOLD ? ma_m : k < lat_m ? mb_m : 8'h0));
      if (k == lat_m) begin
        chk("result", 32'(result), 32'(r_m));
        chk("result_id", 32'(result_id), 32'(id_m));
        chk("result_err", 32'(result_err), 32'(err_m));
      end
    end
    pend_m = !rst_n;
  end
  task automatic do_req(input logic id, input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    @(posedge clk); #1;
    if (id) begin req1 = 1'b1; a1 = a; b1 = b; end
    else begin req0 = 1'b1; a0 = a; b0 = b; end
    @(negedge clk);
    while (!(id ? ack1 : ack0) && n < 300) begin @(negedge clk); n++; end
    chk("ack_seen", 32'(id ? ack1 : ack0), 1);
    @(posedge clk); #1;
    if (id) req1 = 1'b0; else req0 = 1'b0;
  endtask
  task automatic wait_res(output logic [15:0] r, output logic id, output logic e);
    int n = 0;
    @(negedge clk);
    while (!result_valid && n < 300) begin @(negedge clk); n++; end
    chk("res_seen", 32'(result_valid), 1);
    r = result; id = result_id; e = result_err;
  endtask
  logic [15:0] r, rr [4];
  logic rid, rerr, rrid [4];
  initial begin
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_start", 32'(mul_start), 0);
    do_req(1'b0, 8'h05, 8'h03);
    @(negedge clk);
    chk("t1_mdata", 32'(mul_data), 32'h05);
    wait_res(r, rid, rerr);
    chk("t1_res", 32'(r), 32'h000F);
    chk("t1_id", 32'(rid), 0);
    chk("t1_err", 32'(rerr), 0);
    do_req(1'b1, 8'hFB, 8'h06);
    wait_res(r, rid, rerr);
    chk("t2_res", 32'(r), 32'hFFE2);
    chk("t2_id", 32'(rid), 1);
    do_req(1'b0, 8'h0C, 8'h0E);
    wait_res(r, rid, rerr);
    chk("t3_res", 32'(r), 32'h00A8);
    // round robin with both requests held from reset
    @(posedge clk); #1;
    rst_n = 1'b0;
    a0 = 8'h02; b0 = 8'h03; a1 = 8'hFF; b1 = 8'h07;
    req0 = 1'b1; req1 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) wait_res(rr[i], rrid[i], rerr);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rr_id", 32'(rrid[i]), 32'(i % 2));
      chk("rr_res", 32'(rr[i]), (i % 2) ? 32'hFFF9 : 32'h0006);
    end
    mode = 1;
    do_req(1'b0, 8'h07, 8'h09);
    wait_res(r, rid, rerr);
    chk("to_res", 32'(r), 0);
    chk("to_err", 32'(rerr), 1);
    chk("to_id", 32'(rid), 0);
    @(posedge clk); #1 mode = 0;
    do_req(1'b1, 8'h03, 8'h04);
    wait_res(r, rid, rerr);
    chk("after_to_res", 32'(r), 32'h000C);
    chk("after_to_err", 32'(rerr), 0);
    @(posedge clk); #1 mode = 2;
    do_req(1'b0, 8'h10, 8'h02);
    wait_res(r, rid, rerr);
    chk("stale_res", 32'(r), 32'h0020);
    @(posedge clk); #1 mode = 0;
    // reset during the second LOAD_Q cycle
    do_req(1'b0, 8'h05, 8'h03);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_start", 32'(mul_start), 0);
    chk("mid_rst_data", 32'(mul_data), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_valid", 32'(result_valid), 0);
    repeat (20) @(negedge clk);
    do_req(1'b0, 8'h05, 8'h03);
    wait_res(r, rid, rerr);
    chk("post_rst_res", 32'(r), 32'h000F);
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
